lru_wb_cache: RTL

Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement and a burst-based line interface to the next level. It sits between a requester (CPU or upper-level cache) and the next memory level, and is the generalised successor of the fixed 2-way cache. Set count, associativity, line length and data/address widths are all parameters. Dirty-victim writeback and line fill are multi-beat handshaked transfers.

---
 rtl/lru_wb_cache_if.sv | 34 +++
 rtl/lru_wb_cache.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_wb_cache_if.sv
// Requester and next-level bus bundle for lru_wb_cache.
// The cache uses the slave modport; the requester/memory side uses master.
interface lru_wb_cache_if #(
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned DATAWIDTH = 32
);
    logic                 req;
    logic                 we;
    logic [ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0] wdata;
    logic                 ready;
    logic                 done;
    logic [DATAWIDTH-1:0] rdata;
    logic                 mem_req;
    logic                 mem_we;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [DATAWIDTH-1:0] mem_wdata;
    logic                 mem_ack;
    logic [DATAWIDTH-1:0] mem_rdata;
    logic [31:0]          hit_count;
    logic [31:0]          miss_count;

    modport master (
        output req, we, addr, wdata, mem_ack, mem_rdata,
        input  ready, done, rdata, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    modport slave (
        input  req, we, addr, wdata, mem_ack, mem_rdata,
        output ready, done, rdata, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/lru_wb_cache.sv
// N-way set-associative write-back/write-allocate cache with true-LRU ages and burst line transfers.
// Optional hit/miss statistics counters are compiled in with `define CACHE_STATS_EN.
module lru_wb_cache #(
    parameter int unsigned SETS      = 16,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned LINEWORDS = 4,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lru_wb_cache_if.slave bus
);
    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned OFFW = $clog2(LINEWORDS);
    localparam int unsigned WAYW = $clog2(WAYS);
    localparam int unsigned TAGW = ADDRWIDTH - IDXW - OFFW;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LOOKUP  = 3'd2;
    localparam logic [2:0] S_WB      = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;
    localparam logic [2:0] S_RESPOND = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [IDXW-1:0]      init_q, init_d;
    logic [OFFW-1:0]      beat_q, beat_d;
    logic [WAYW-1:0]      acc_way_q, acc_way_d;
    logic                 we_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0] wdata_q;

    logic                 ready_q, done_q, mem_req_q, mem_we_q;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                 valid_q [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic [TAGW-1:0]      tag_q   [SETS][WAYS];
    logic [WAYW-1:0]      age_q   [SETS][WAYS];
    logic [DATAWIDTH-1:0] data_q  [SETS][WAYS][LINEWORDS];

    logic [IDXW-1:0]      idx_c;
    logic [OFFW-1:0]      off_c;
    logic [TAGW-1:0]      rtag_c;
    logic                 hit_c, inv_found_c;
    logic [WAYW-1:0]      hit_way_c, inv_way_c, old_way_c, victim_c;
    logic                 beat_ack_c, last_beat_c;

    assign idx_c       = addr_q[OFFW +: IDXW];
    assign off_c       = addr_q[OFFW-1:0];
    assign rtag_c      = addr_q[ADDRWIDTH-1 -: TAGW];
    assign beat_ack_c  = bus.mem_ack && mem_req_q;
    assign last_beat_c = (beat_q == OFFW'(LINEWORDS - 1));

    // Tag compare and victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        old_way_c   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx_c][WAYW'(w)] && (tag_q[idx_c][WAYW'(w)] == rtag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAYW'(w);
            end
            if (!valid_q[idx_c][WAYW'(w)] && !inv_found_c) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAYW'(w);
            end
            if (age_q[idx_c][WAYW'(w)] == WAYW'(WAYS - 1)) begin
                old_way_c = WAYW'(w);
            end
        end
        victim_c = inv_found_c ? inv_way_c : old_way_c;
    end

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        beat_d    = beat_q;
        acc_way_d = acc_way_q;
        case (state_q)
            S_INIT: begin
                init_d = init_q + 1'b1;
                if (init_q == IDXW'(SETS - 1)) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                beat_d = '0;
                if (hit_c) begin
                    acc_way_d = hit_way_c;
                    state_d   = S_RESPOND;
                end else begin
                    acc_way_d = victim_c;
                    state_d   = (valid_q[idx_c][victim_c] && dirty_q[idx_c][victim_c]) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                if (beat_ack_c) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat_c) state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (beat_ack_c) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat_c) state_d = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    // Registered outputs are computed from the next state so they align with it.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        if (state_d == S_WB) begin
            mem_addr_d  = {tag_q[idx_c][acc_way_d], idx_c, beat_d};
            mem_wdata_d = data_q[idx_c][acc_way_d][beat_d];
        end else if (state_d == S_FILL) begin
            mem_addr_d  = {rtag_c, idx_c, beat_d};
        end
        if (state_d == S_RESPOND) begin
            // The final fill word is not in the array yet, so forward it.
            if ((state_q == S_FILL) && (beat_q == off_c)) rdata_d = bus.mem_rdata;
            else                                          rdata_d = data_q[idx_c][acc_way_d][off_c];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_INIT;
            init_q      <= '0;
            beat_q      <= '0;
            acc_way_q   <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            beat_q      <= beat_d;
            acc_way_q   <= acc_way_d;
            ready_q     <= (state_d == S_IDLE);
            done_q      <= (state_d == S_RESPOND);
            rdata_q     <= rdata_d;
            mem_req_q   <= (state_d == S_WB) || (state_d == S_FILL);
            mem_we_q    <= (state_d == S_WB);
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;

            if ((state_q == S_IDLE) && bus.req) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end

            if (state_q == S_INIT) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[init_q][WAYW'(w)] <= 1'b0;
                    dirty_q[init_q][WAYW'(w)] <= 1'b0;
                    age_q[init_q][WAYW'(w)]   <= WAYW'(w);
                end
            end

            if ((state_q == S_FILL) && beat_ack_c) begin
                data_q[idx_c][acc_way_q][beat_q] <= bus.mem_rdata;
                if (last_beat_c) begin
                    valid_q[idx_c][acc_way_q] <= 1'b1;
                    dirty_q[idx_c][acc_way_q] <= 1'b0;
                    tag_q[idx_c][acc_way_q]   <= rtag_c;
                end
            end

            // Completion: apply the write and promote the accessed way to most recent.
            if (state_q == S_RESPOND) begin
                if (we_q) begin
                    data_q[idx_c][acc_way_q][off_c] <= wdata_q;
                    dirty_q[idx_c][acc_way_q]       <= 1'b1;
                end
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAYW'(w) == acc_way_q) begin
                        age_q[idx_c][WAYW'(w)] <= '0;
                    end else if (age_q[idx_c][WAYW'(w)] < age_q[idx_c][acc_way_q]) begin
                        age_q[idx_c][WAYW'(w)] <= age_q[idx_c][WAYW'(w)] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic        was_hit_q;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating hit/miss statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            was_hit_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == S_LOOKUP) begin
                was_hit_q <= hit_c;
                if (!hit_c && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if ((state_q == S_RESPOND) && was_hit_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`else
    assign bus.hit_count  = 32'd0;
    assign bus.miss_count = 32'd0;
`endif

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
